// File: rtl/quotient_bcd_conv_pkg.sv
// Shared constants and FSM encoding for the quotient-to-BCD converter.
package qbcd_pkg;

  localparam int unsigned QBCD_WIDTH  = 16;
  localparam int unsigned QBCD_DIGITS = 5;
  localparam logic [3:0]  QBCD_BLANK  = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } qbcd_state_e;

endpackage

// File: rtl/quotient_bcd_conv_if.sv
// Divider-to-converter link: quotient and ready level in, BCD result and status out.
interface quotient_bcd_conv_if;
  import qbcd_pkg::*;

  logic                         start;
  logic [QBCD_WIDTH-1:0]        bin_in;
  logic                         busy;
  logic                         done;
  logic [4*QBCD_DIGITS-1:0]     bcd_out;

  modport master (output start, bin_in, input busy, done, bcd_out);
  modport slave  (input start, bin_in, output busy, done, bcd_out);

endinterface

// File: rtl/quotient_bcd_conv_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more, no carry out.
module bcd_digit_adj (
  input  logic [3:0] in,
  output logic [3:0] out
);

  always_comb begin
    out = (in >= 4'd5) ? in + 4'd3 : in;
  end

endmodule

// File: rtl/quotient_bcd_conv.sv
// Sequential binary-to-BCD converter, one bit per clock, triggered on the rising edge of start.
// Optional: define QBCD_BLANK_EN to replace leading zero digits with the display blank code.
module quotient_bcd_conv
  import qbcd_pkg::*;
#(
  parameter int unsigned WIDTH  = QBCD_WIDTH,
  parameter int unsigned DIGITS = QBCD_DIGITS
) (
  input  logic               clk,
  input  logic               reset,
  quotient_bcd_conv_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  qbcd_state_e           state;
  logic                  start_d;
  logic [CW-1:0]         count;
  logic [WIDTH-1:0]      bin_sr;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   result;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  busy_q;
  logic                  done_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .in  (scratch[4*g +: 4]),
      .out (adj[4*g +: 4])
    );
  end

`ifdef QBCD_BLANK_EN
  logic blank_run;
`endif

  always_comb begin
    result = scratch;
`ifdef QBCD_BLANK_EN
    // Walk from the top digit down, blanking zeros until the first non-zero; units always shown.
    blank_run = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      if (blank_run && (scratch[4*i +: 4] == 4'd0)) begin
        result[4*i +: 4] = QBCD_BLANK;
      end else begin
        blank_run = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_d <= 1'b0;
      count   <= '0;
      bin_sr  <= '0;
      scratch <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_d <= bus.start;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !start_d) begin
            bin_sr  <= bus.bin_in;
            scratch <= '0;
            count   <= '0;
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Top adjusted bit falls off the end; it cannot be set for a 16-bit input.
          {scratch, bin_sr} <= {adj[4*DIGITS-2:0], bin_sr, 1'b0};
          count <= count + 1'b1;
          if (count == LAST) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          bcd_q  <= result;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: doc/quotient_bcd_conv.md
Name: quotient_bcd_conv

Overview:
- Downstream stage of the repeated-subtraction 16-bit divider.
- Consumes the divider's 16-bit quotient when the divider's ready level rises.
- Converts the quotient to 5-digit packed BCD for the lab's seven-segment display path.
- Uses sequential shift-and-add-3 (double dabble), one bit per clock.

Parameters:
- WIDTH, 16, binary input width; fixed to match the divider output.
- DIGITS, 5, BCD digit count; 5 covers 0..65535; bcd_out width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level from divider ready; a conversion is triggered by its rising edge.
- bin_in  input  16  quotient from divider; sampled only on the trigger cycle.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out has been updated.
- bcd_out  output  20  packed BCD; digit 0 (units) in [3:0], digit 4 in [19:16].

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, done=0, bcd_out=20'h00000.
  - Internal shift register, bit counter and start_d are cleared.
- Edge detect:
  - start_d registers start every cycle.
  - trigger = start & ~start_d & (state==IDLE).
  - If start is already high when reset releases, the first clock counts as an edge.
- States:
  - IDLE: busy=0. On trigger, capture bin_in into shift register, clear BCD scratch to 0, count=0, go to SHIFT. busy=1 from the next cycle.
  - SHIFT: each cycle, every scratch digit >=5 gets +3 (via bcd_digit_adj), then {scratch,bin} shifts left by 1 and count increments. After the 16th shift (count==15 at the edge), go to DONE.
  - DONE: bcd_out <= scratch, done=1 for exactly this one cycle, busy=0, then IDLE.
- Latency:
  - Trigger seen at edge k → shifts at edges k+1..k+16 → bcd_out valid and done=1 after edge k+17.
  - Total 17 cycles from trigger to result.
- bcd_out holds its last result until the next DONE; it is not cleared at trigger.
- Start edges while busy or in DONE are ignored and not queued. start_d still tracks, so a level held high does not retrigger.
- bin_in changes after the trigger cycle have no effect.
- Reset mid-conversion aborts immediately to reset values; the partial result is discarded.
- Width rule: digit adjust is 4-bit with no carry out. Scratch is 20 bits; the final left-shift carry from digit 4 is dropped, which is unreachable for WIDTH=16.

Optional Feature:
- Macro: QBCD_BLANK_EN.
- Defined: at DONE, leading zero digits (most significant first, stopping at the first non-zero) are written as 4'hF, the display blank code. Digit 0 is never blanked; value 0 gives 20'hFFFF0.
- Undefined: raw BCD with leading zeros. No extra logic.

Decomposition:
- Shared package qbcd_pkg holds:
  - constants QBCD_WIDTH=16, QBCD_DIGITS=5, QBCD_BLANK=4'hF.
  - state encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
- One sub-module, bcd_digit_adj: 4-bit combinational, out = (in>=5) ? in+3 : in. Instantiated DIGITS times.
- Top level holds the FSM, counter, edge detect and output register.

Test Plan:
- Reset released with start=0; then bin_in=11 (123/11 quotient), start 0→1 → busy high 16 cycles, done pulse at cycle 17, bcd_out=20'h00011.
- bin_in=65535, start edge → bcd_out=20'h65535. Then bin_in=0 with a new edge → 20'h00000 (QBCD_BLANK_EN: 20'hFFFF0).
- start held high 40 cycles after one edge → exactly one done pulse. Toggle start during busy → no second conversion, result unchanged.
- Change bin_in from 100 to 999 one cycle after the trigger → bcd_out=20'h00100.
- Assert reset at shift 8 of bin_in=4660 → busy=0, done=0, bcd_out=0 immediately. New edge after release → 20'h04660.
- QBCD_BLANK_EN with bin_in=305 → bcd_out=20'hFF305. With bin_in=10000 → 20'h10000.
